hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Hazard and forwarding unit for the 5-stage MIPS pipeline, extended for a multi-cycle multiply/divide unit.
- Keeps the classic load-use stall, branch stall, and D/E forwarding; register-address width is parametrised.
- Adds a latency counter that tracks an in-flight mult/div launched from E. D-stage HI/LO readers and further mult/div ops stall until the result is ready.
- Sits between the datapath stage registers and the controller; drives the F/D stall enables, the E flush and all forwarding muxes.

Parameters:
- REGBITS, 5, register-address width; register 0 is hard-wired zero.
- MULLAT, 4, cycles from mult launch in E until HI/LO are valid (>=1).
- DIVLAT, 32, cycles from div launch in E until HI/LO are valid (>=1, >=MULLAT).
- CNTW, $clog2(DIVLAT+1), latency counter width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- branchD  in  1  branch instruction in D
- rsD, rtD  in  REGBITS  D-stage source registers
- rsE, rtE  in  REGBITS  E-stage source registers
- writeregE, writeregM, writeregW  in  REGBITS  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  destination write enable per stage
- memtoregE, memtoregM  in  1  load instruction in E / M
- mdstartE  in  1  mult/div instruction in E this cycle
- mddivE  in  1  qualifies mdstartE: 1=divide (DIVLAT), 0=multiply (MULLAT)
- hiloreadD  in  1  mfhi/mflo in D
- mdopD  in  1  mult/div instruction in D
- stallF, stallD  out  1  active-high hold of PC / IF-ID register
- flushE  out  1  clear ID-EX register at next edge
- forwardAD, forwardBD  out  1  branch-comparator forward from M
- forwardAE, forwardBE  out  2  ALU operand select: 00 regfile, 01 W result, 10 M result
- mdbusy  out  1  mult/div in flight
- mddone  out  1  one-cycle pulse when HI/LO become valid

Behaviour:
- Forwarding is purely combinational.
  - forwardAE = 10 if rsE!=0 & rsE==writeregM & regwriteM; else 01 if rsE!=0 & rsE==writeregW & regwriteW; else 00. M has priority over W.
  - forwardBE uses the same rule on rtE.
  - forwardAD = rsD!=0 & rsD==writeregM & regwriteM; forwardBD uses the same rule on rtD.
- lwstall = memtoregE & rtE!=0 & (rsD==rtE | rtD==rtE). A register-0 target never stalls.
- branchstall = branchD & ((regwriteE & writeregE!=0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM!=0 & writeregM∈{rsD,rtD})).
- Latency counter cnt (CNTW bits) is registered; reset value 0.
  - mdstartE: cnt <= DIVLAT if mddivE, else MULLAT.
  - Otherwise, if cnt!=0: cnt <= cnt-1.
  - mdstartE while cnt!=0 is a protocol violation (prevented by mdstall). If it occurs, the counter reloads from the new op; no error flag is raised.
- mdbusy = (cnt!=0), combinational from the register; 0 out of reset.
- mddone is registered: asserted for exactly one cycle in the cycle where cnt has just reached 0 from 1, i.e. the cycle after cnt==1. Reset value 0.
- mdstall = (hiloreadD | mdopD) & (mdbusy | mdstartE).
- Timing: an op in E at cycle t stalls a dependent D instruction in cycles t..t+LAT; that instruction advances at the edge ending cycle t+LAT+1, when mddone=1.
- stallF = stallD = flushE = lwstall | branchstall | mdstall. All are combinational, with no extra latency.
- Reset (reset_n=0 at an edge), including mid-operation: cnt->0 and mddone->0 at that edge. mdbusy and mdstall drop in the next cycle; forwarding outputs are unaffected.
- Simultaneous events:
  - A load-use stall and an active mult/div both assert stall. The counter keeps decrementing during stalls, because the unit runs independently of the pipeline.
  - A flushE in the same cycle as mdstartE still launches the op, since the E instruction is valid in that cycle.

Test Plan:
- Forwarding priority: rsE=rtE=5, writeregM=5/regwriteM=1, writeregW=5/regwriteW=1 -> forwardAE=forwardBE=10. Repeat with regwriteM=0 -> 01. Repeat with rsE=rtE=0 -> 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1. Repeat with rtE=0 -> all 0.
- Branch stall: branchD=1, regwriteE=1, writeregE=9, rtD=9 -> stall. Next cycle, writeregM=9/regwriteM=1/memtoregM=0 -> no stall, forwardBD=1.
- Multiply: mdstartE=1, mddivE=0 at cycle t, then hiloreadD=1 held -> stall high t..t+4, mdbusy high t+1..t+4, mddone=1 at t+5, stall low at t+5.
- Divide back-to-back: div in E at t, mdopD=1 -> stall t..t+32, mddone at t+33, then new mdstartE reloads cnt=MULLAT.
- Reset mid-divide: reset_n=0 at t+10 -> cnt=0, mdbusy=0, mddone=0 at t+11, no mddone pulse afterwards.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding unit for the 5-stage MIPS pipeline with a
// multi-cycle multiply/divide unit. Forwarding and stall decisions are
// combinational. A small latency counter tracks the in-flight mult/div so
// that HI/LO readers and further mult/div ops in D wait for the result.
module hazard_unit_mc #(
  parameter int REGBITS = 5,
  parameter int MULLAT  = 4,
  parameter int DIVLAT  = 32,
  parameter int CNTW    = $clog2(DIVLAT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               branchD,
  input  logic [REGBITS-1:0] rsD,
  input  logic [REGBITS-1:0] rtD,
  input  logic [REGBITS-1:0] rsE,
  input  logic [REGBITS-1:0] rtE,
  input  logic [REGBITS-1:0] writeregE,
  input  logic [REGBITS-1:0] writeregM,
  input  logic [REGBITS-1:0] writeregW,
  input  logic               regwriteE,
  input  logic               regwriteM,
  input  logic               regwriteW,
  input  logic               memtoregE,
  input  logic               memtoregM,
  input  logic               mdstartE,
  input  logic               mddivE,
  input  logic               hiloreadD,
  input  logic               mdopD,
  output logic               stallF,
  output logic               stallD,
  output logic               flushE,
  output logic               forwardAD,
  output logic               forwardBD,
  output logic [1:0]         forwardAE,
  output logic [1:0]         forwardBE,
  output logic               mdbusy,
  output logic               mddone
);

  localparam logic [CNTW-1:0] LP_MULLAT = CNTW'(MULLAT);
  localparam logic [CNTW-1:0] LP_DIVLAT = CNTW'(DIVLAT);
  localparam logic [CNTW-1:0] LP_ONE    = CNTW'(1);

  logic [CNTW-1:0] r_cnt;
  logic            r_mddone;
  logic            w_lwstall;
  logic            w_branchstall;
  logic            w_mdstall;
  logic            w_stall;

  // E-stage ALU operand forwarding; the younger M result wins over W.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if ((rsE != '0) && (rsE == writeregM) && regwriteM)
      forwardAE = 2'b10;
    else if ((rsE != '0) && (rsE == writeregW) && regwriteW)
      forwardAE = 2'b01;
    if ((rtE != '0) && (rtE == writeregM) && regwriteM)
      forwardBE = 2'b10;
    else if ((rtE != '0) && (rtE == writeregW) && regwriteW)
      forwardBE = 2'b01;
  end

  // D-stage branch comparator forwarding from the M-stage ALU result.
  always_comb begin
    forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;
  end

  // Stall sources: load-use, branch operand not yet available, mult/div busy.
  always_comb begin
    w_lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    w_branchstall = branchD &&
      ((regwriteE && (writeregE != '0) &&
        ((writeregE == rsD) || (writeregE == rtD))) ||
       (memtoregM && (writeregM != '0) &&
        ((writeregM == rsD) || (writeregM == rtD))));
    w_mdstall = (hiloreadD || mdopD) && (mdbusy || mdstartE);
    w_stall   = w_lwstall || w_branchstall || w_mdstall;
  end

  // Latency counter: loads on launch, otherwise counts down to zero. It runs
  // regardless of pipeline stalls; a launch while busy simply reloads it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      r_cnt    <= '0;
      r_mddone <= 1'b0;
    end else begin
      r_mddone <= !mdstartE && (r_cnt == LP_ONE);
      if (mdstartE)
        r_cnt <= mddivE ? LP_DIVLAT : LP_MULLAT;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - LP_ONE;
    end
  end

  assign mdbusy = (r_cnt != '0);
  assign mddone = r_mddone;
  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;

endmodule
